// File: rtl/mat_calc_scheduler.sv
// rtl/mat_calc_scheduler.sv - matrix operation sequencer with one shared multiplier
package mat_calc_pkg;
  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_ADD        = 3'd1,
    OP_SCALAR_MUL = 3'd2,
    OP_TRANSPOSE  = 3'd3,
    OP_MAT_MUL    = 3'd4,
    OP_CONV       = 3'd5
  } op_code_t;
endpackage

module mat_calc_scheduler
  import mat_calc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 20,
  parameter int DIM_W   = 3,
  parameter int MAX_DIM = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  op_code_t                 op_code,
  input  logic        [DIM_W-1:0]  a_rows,
  input  logic        [DIM_W-1:0]  a_cols,
  input  logic        [DIM_W-1:0]  b_rows,
  input  logic        [DIM_W-1:0]  b_cols,
  input  logic signed [DATA_W-1:0] scalar,
  output logic                     rd_en,
  output logic                     rd_sel,
  output logic        [DIM_W-1:0]  rd_row,
  output logic        [DIM_W-1:0]  rd_col,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     wr_en,
  output logic        [DIM_W-1:0]  wr_row,
  output logic        [DIM_W-1:0]  wr_col,
  output logic signed [RES_W-1:0]  wr_data,
  output logic        [DIM_W-1:0]  res_rows,
  output logic        [DIM_W-1:0]  res_cols,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RD_A, S_RD_B, S_ACC, S_WR, S_DONE} state_t;

  state_t                    state;
  op_code_t                  op_q;
  logic        [DIM_W-1:0]   ar_q, ac_q, br_q, bc_q;
  logic        [DIM_W-1:0]   i_q, j_q, k_q;
  logic signed [DATA_W-1:0]  scalar_q, a_q;
  logic signed [RES_W-1:0]   acc_q;
  logic                      err_q;

  logic signed [DATA_W-1:0]   mul_a;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [RES_W-1:0]    prod_ext, a_ext, d_ext;
  logic        [DIM_W-1:0]    col_lim;
  logic                       last_i, last_j, last_k, chk_err;

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (d > DIM_W'(MAX_DIM));
  endfunction

  // The multiplier serves the scalar product in WR and the dot-product term in ACC.
  assign mul_a    = (state == S_ACC) ? a_q : scalar_q;
  assign prod     = mul_a * rd_data;
  assign prod_ext = {{(RES_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign a_ext    = {{(RES_W-DATA_W){a_q[DATA_W-1]}}, a_q};
  assign d_ext    = {{(RES_W-DATA_W){rd_data[DATA_W-1]}}, rd_data};

  assign col_lim = (op_q == OP_MAT_MUL) ? bc_q : ac_q;
  assign last_i  = (i_q == ar_q - DIM_W'(1));
  assign last_j  = (j_q == col_lim - DIM_W'(1));
  assign last_k  = (k_q == ac_q - DIM_W'(1));

  always_comb begin
    chk_err = 1'b0;
    case (op_q)
      OP_ADD:        chk_err = dim_bad(ar_q) || dim_bad(ac_q) || dim_bad(br_q) || dim_bad(bc_q)
                               || (ar_q != br_q) || (ac_q != bc_q);
      OP_SCALAR_MUL,
      OP_TRANSPOSE:  chk_err = dim_bad(ar_q) || dim_bad(ac_q);
      OP_MAT_MUL:    chk_err = dim_bad(ar_q) || dim_bad(ac_q) || dim_bad(br_q) || dim_bad(bc_q)
                               || (ac_q != br_q);
      default:       chk_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_NONE;
      ar_q     <= '0;
      ac_q     <= '0;
      br_q     <= '0;
      bc_q     <= '0;
      scalar_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
      res_rows <= '0;
      res_cols <= '0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q     <= op_code;
          ar_q     <= a_rows;
          ac_q     <= a_cols;
          br_q     <= b_rows;
          bc_q     <= b_cols;
          scalar_q <= scalar;
          i_q      <= '0;
          j_q      <= '0;
          k_q      <= '0;
          acc_q    <= '0;
          err_q    <= 1'b0;
          state    <= S_CHECK;
        end
        S_CHECK: if (chk_err) begin
          err_q <= 1'b1;
          state <= S_DONE;
        end else begin
          res_rows <= (op_q == OP_TRANSPOSE) ? ac_q : ar_q;
          res_cols <= (op_q == OP_TRANSPOSE) ? ar_q : col_lim;
          state    <= S_RD_A;
        end
        S_RD_A: state <= (op_q == OP_ADD || op_q == OP_MAT_MUL) ? S_RD_B : S_WR;
        S_RD_B: begin
          a_q   <= rd_data;
          state <= (op_q == OP_ADD) ? S_WR : S_ACC;
        end
        S_ACC: begin
          acc_q <= acc_q + prod_ext;
          if (last_k) begin
            k_q   <= '0;
            state <= S_WR;
          end else begin
            k_q   <= k_q + DIM_W'(1);
            state <= S_RD_A;
          end
        end
        S_WR: begin
          acc_q <= '0;
          state <= S_RD_A;
          if (!last_j) begin
            j_q <= j_q + DIM_W'(1);
          end else begin
            j_q <= '0;
            if (last_i) begin
              i_q   <= '0;
              state <= S_DONE;
            end else begin
              i_q <= i_q + DIM_W'(1);
            end
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes and addresses decode from state; abort squashes them within the same cycle.
  always_comb begin
    rd_en   = 1'b0;
    rd_sel  = 1'b0;
    rd_row  = '0;
    rd_col  = '0;
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_col  = '0;
    wr_data = '0;
    if (!abort) begin
      case (state)
        S_RD_A: begin
          rd_en  = 1'b1;
          rd_row = i_q;
          rd_col = (op_q == OP_MAT_MUL) ? k_q : j_q;
        end
        S_RD_B: begin
          rd_en  = 1'b1;
          rd_sel = 1'b1;
          rd_row = (op_q == OP_MAT_MUL) ? k_q : i_q;
          rd_col = j_q;
        end
        S_WR: begin
          wr_en  = 1'b1;
          wr_row = (op_q == OP_TRANSPOSE) ? j_q : i_q;
          wr_col = (op_q == OP_TRANSPOSE) ? i_q : j_q;
          case (op_q)
            OP_ADD:        wr_data = a_ext + d_ext;
            OP_SCALAR_MUL: wr_data = prod_ext;
            OP_TRANSPOSE:  wr_data = d_ext;
            default:       wr_data = acc_q;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = done && err_q;

endmodule

// File: tb/tb_mat_calc_scheduler.sv
// tb/tb_mat_calc_scheduler.sv - self-checking bench for mat_calc_scheduler
module tb_mat_calc_scheduler;
  import mat_calc_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  op_code_t          op_code;
  logic        [2:0] a_rows, a_cols, b_rows, b_cols;
  logic signed [7:0] scalar;
  logic              rd_en, rd_sel;
  logic        [2:0] rd_row, rd_col;
  logic signed [7:0] rd_data = '0;
  logic              wr_en;
  logic        [2:0] wr_row, wr_col;
  logic signed [19:0] wr_data;
  logic        [2:0] res_rows, res_cols;
  logic              busy, done, err;

  mat_calc_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_code(op_code),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols), .scalar(scalar),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .res_rows(res_rows), .res_cols(res_cols), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic signed [7:0] mem_a [0:7][0:7];
  logic signed [7:0] mem_b [0:7][0:7];

  always @(posedge clk)
    rd_data <= rd_en ? (rd_sel ? mem_b[rd_row][rd_col] : mem_a[rd_row][rd_col]) : 8'sd0;

  typedef struct { int cyc; int row; int col; int val; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];

  int n_checks = 0, n_errors = 0;
  int rd_cnt, done_cyc, err_seen, busy_after, stray_err, got_rows, got_cols;
  int exp_err, exp_rows, exp_cols, exp_done;

  typedef struct {
    op_code_t op;
    int ar, ac, br, bc, sc;
    int xerr, xrows, xcols, xdone, nvals;
  } vec_t;
  vec_t tbl [7];
  int   plan_vals [7][6];

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int wrap20(input longint v);
    logic [19:0] t;
    t = v[19:0];
    return int'($signed(t));
  endfunction

  function automatic bit dim_ok(input int d);
    return d >= 1 && d <= 5;
  endfunction

  // Reference: expected write stream from the arithmetic definition and the per-element cost.
  task automatic build_model(input op_code_t op, input int ar, ac, br, bc, sc);
    int cpe, e;
    longint s;
    exp_q.delete();
    cpe = 0;
    exp_rows = ar; exp_cols = ac;
    case (op)
      OP_ADD:        begin exp_err = !(dim_ok(ar) && dim_ok(ac) && dim_ok(br) && dim_ok(bc) && ar == br && ac == bc); cpe = 3; end
      OP_SCALAR_MUL: begin exp_err = !(dim_ok(ar) && dim_ok(ac)); cpe = 2; end
      OP_TRANSPOSE:  begin exp_err = !(dim_ok(ar) && dim_ok(ac)); cpe = 2; exp_rows = ac; exp_cols = ar; end
      OP_MAT_MUL:    begin exp_err = !(dim_ok(ar) && dim_ok(ac) && dim_ok(br) && dim_ok(bc) && ac == br);
                           cpe = 3 * ac + 1; exp_cols = bc; end
      default:       exp_err = 1;
    endcase
    if (exp_err) begin
      exp_done = 2;
      return;
    end
    e = 0;
    for (int i = 0; i < ar; i++) begin
      for (int j = 0; j < ((op == OP_MAT_MUL) ? bc : ac); j++) begin
        case (op)
          OP_ADD:        s = longint'(mem_a[i][j]) + longint'(mem_b[i][j]);
          OP_SCALAR_MUL: s = longint'(sc) * longint'(mem_a[i][j]);
          OP_TRANSPOSE:  s = longint'(mem_a[i][j]);
          default: begin
            s = 0;
            for (int k = 0; k < ac; k++) s += longint'(mem_a[i][k]) * longint'(mem_b[k][j]);
          end
        endcase
        if (op == OP_TRANSPOSE) exp_q.push_back('{1 + (e + 1) * cpe, j, i, wrap20(s)});
        else                    exp_q.push_back('{1 + (e + 1) * cpe, i, j, wrap20(s)});
        e++;
      end
    end
    exp_done = 2 + e * cpe;
  endtask

  task automatic run_op(input op_code_t op, input int ar, ac, br, bc, sc, input int abort_at, input int max_cyc);
    got_q.delete();
    rd_cnt = 0; done_cyc = -1; err_seen = 0; busy_after = -1; stray_err = 0;
    @(posedge clk); #1;
    op_code = op; a_rows = 3'(ar); a_cols = 3'(ac); b_rows = 3'(br); b_cols = 3'(bc);
    scalar = 8'(sc); start = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (wr_en) got_q.push_back('{c, int'(wr_row), int'(wr_col), int'(wr_data)});
      if (rd_en) rd_cnt++;
      if (err && !done) stray_err++;
      if (done && done_cyc < 0) begin done_cyc = c; err_seen = int'(err); end
      if (abort_at >= 0 && c == abort_at + 1) busy_after = int'(busy);
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        busy_after = int'(busy); got_rows = int'(res_rows); got_cols = int'(res_cols);
        break;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        // Scramble inputs while busy; a repeated start in CHECK must be ignored too.
        op_code = op_code_t'(3'($urandom_range(0, 7)));
        a_rows = 3'($urandom); a_cols = 3'($urandom); b_rows = 3'($urandom); b_cols = 3'($urandom);
        scalar = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      abort = (c + 1 == abort_at);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " err"}, err_seen, exp_err);
    check({tag, " stray_err"}, stray_err, 0);
    check({tag, " busy_after_done"}, busy_after, 0);
    check({tag, " n_writes"}, got_q.size(), exp_q.size());
    if (exp_err) check({tag, " rd_count"}, rd_cnt, 0);
    else begin
      check({tag, " res_rows"}, got_rows, exp_rows);
      check({tag, " res_cols"}, got_cols, exp_cols);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] != exp_q[i]) begin
        n_errors++;
        $display("FAIL %s write%0d: got cyc=%0d (%0d,%0d)=%0d expected cyc=%0d (%0d,%0d)=%0d", tag, i,
                 got_q[i].cyc, got_q[i].row, got_q[i].col, got_q[i].val,
                 exp_q[i].cyc, exp_q[i].row, exp_q[i].col, exp_q[i].val);
      end
    end
  endtask

  task automatic load_plan(input int id);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin mem_a[r][c] = 8'sd0; mem_b[r][c] = 8'sd0; end
    if (id == 0 || id == 6) begin
      mem_a[0][0] = 1;  mem_a[0][1] = 2;   mem_a[1][0] = 3;  mem_a[1][1] = 4;
      mem_b[0][0] = 10; mem_b[0][1] = -20; mem_b[1][0] = 30; mem_b[1][1] = 127;
    end else if (id == 1) begin
      mem_a[0][0] = -128; mem_a[0][1] = 5; mem_a[0][2] = 0;
    end else begin
      mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[0][2] = 3;
      mem_a[1][0] = 4; mem_a[1][1] = 5; mem_a[1][2] = 6;
      mem_b[0][0] = 7;  mem_b[0][1] = 8;  mem_b[1][0] = 9;
      mem_b[1][1] = 10; mem_b[2][0] = 11; mem_b[2][1] = 12;
    end
  endtask

  task automatic run_plan(input int id);
    string tag;
    tag = $sformatf("plan%0d", id);
    load_plan(id);
    build_model(tbl[id].op, tbl[id].ar, tbl[id].ac, tbl[id].br, tbl[id].bc, tbl[id].sc);
    run_op(tbl[id].op, tbl[id].ar, tbl[id].ac, tbl[id].br, tbl[id].bc, tbl[id].sc, -1, 100);
    check({tag, " tbl_done"}, done_cyc, tbl[id].xdone);
    check({tag, " tbl_err"}, err_seen, tbl[id].xerr);
    check({tag, " tbl_nwr"}, got_q.size(), tbl[id].nvals);
    if (!tbl[id].xerr) begin
      check({tag, " tbl_rows"}, got_rows, tbl[id].xrows);
      check({tag, " tbl_cols"}, got_cols, tbl[id].xcols);
    end
    for (int i = 0; i < tbl[id].nvals && i < got_q.size(); i++)
      check($sformatf("%s tbl_val%0d", tag, i), got_q[i].val, plan_vals[id][i]);
    compare_model(tag);
  endtask

  initial begin
    tbl[0] = '{OP_ADD,        2, 2, 2, 2, 0,    0, 2, 2, 14, 4};
    tbl[1] = '{OP_SCALAR_MUL, 1, 3, 0, 0, -128, 0, 1, 3, 8,  3};
    tbl[2] = '{OP_TRANSPOSE,  2, 3, 0, 0, 0,    0, 3, 2, 14, 6};
    tbl[3] = '{OP_MAT_MUL,    2, 3, 3, 2, 0,    0, 2, 2, 42, 4};
    tbl[4] = '{OP_MAT_MUL,    2, 3, 2, 2, 0,    1, 0, 0, 2,  0};
    tbl[5] = '{OP_MAT_MUL,    0, 3, 3, 2, 0,    1, 0, 0, 2,  0};
    tbl[6] = '{OP_CONV,       2, 2, 2, 2, 0,    1, 0, 0, 2,  0};
    plan_vals[0] = '{11, -18, 33, 131, 0, 0};
    plan_vals[1] = '{16384, -640, 0, 0, 0, 0};
    plan_vals[2] = '{1, 2, 3, 4, 5, 6};
    plan_vals[3] = '{58, 64, 139, 154, 0, 0};
    plan_vals[4] = '{0, 0, 0, 0, 0, 0};
    plan_vals[5] = '{0, 0, 0, 0, 0, 0};
    plan_vals[6] = '{0, 0, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; op_code = OP_NONE;
    a_rows = '0; a_cols = '0; b_rows = '0; b_cols = '0; scalar = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", int'({rd_en, rd_sel, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
                                 res_rows, res_cols, busy, done, err} != '0), 0);

    for (int v = 0; v < 7; v++) run_plan(v);

    // Abort during the second ACC of the matrix product, then a clean ADD.
    load_plan(3);
    run_op(OP_MAT_MUL, 2, 3, 3, 2, 0, 7, 30);
    check("abort n_writes", got_q.size(), 0);
    check("abort no_done", done_cyc, -1);
    check("abort busy_next", busy_after, 0);
    run_plan(0);

    // Reset in the middle of an operation behaves like power-on reset.
    load_plan(3);
    @(posedge clk); #1;
    op_code = OP_MAT_MUL; a_rows = 3'd2; a_cols = 3'd3; b_rows = 3'd3; b_cols = 3'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_outputs", int'({rd_en, wr_en, wr_data, res_rows, res_cols, busy, done, err} != '0), 0);
    run_plan(0);

    for (int t = 0; t < 40; t++) begin
      op_code_t op;
      int ar, ac, br, bc, sc, pick;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin mem_a[r][c] = 8'($urandom); mem_b[r][c] = 8'($urandom); end
      pick = $urandom_range(0, 19);
      op = (pick < 4) ? OP_ADD : (pick < 8) ? OP_SCALAR_MUL : (pick < 12) ? OP_TRANSPOSE :
           (pick < 18) ? OP_MAT_MUL : op_code_t'(3'($urandom_range(0, 7)));
      ar = $urandom_range(1, 5); ac = $urandom_range(1, 5); bc = $urandom_range(1, 5);
      br = (op == OP_MAT_MUL) ? ac : ar;
      if (op == OP_ADD) bc = ac;
      if ($urandom_range(0, 6) == 0) begin
        ar = $urandom_range(0, 7); br = $urandom_range(0, 7); ac = $urandom_range(0, 7);
      end
      sc = int'($signed(8'($urandom)));
      build_model(op, ar, ac, br, bc, sc);
      run_op(op, ar, ac, br, bc, sc, -1, 500);
      compare_model($sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
